// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared FSM state encoding and default parameters for pc_gen
package pc_gen_pkg;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
  localparam int          DEF_XLEN         = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;
  localparam int          DEF_ILEN_BYTES   = 4;
  localparam int          DEF_HIST_DEPTH   = 4;
endpackage

// File: rtl/pc_hist_ring.sv
// pc_hist_ring: ring of recently issued PCs, index 0 is the newest entry
module pc_hist_ring #(
  parameter int XLEN = 32,
  parameter int HIST_DEPTH = 4,
  localparam int IW = $clog2(HIST_DEPTH)
) (
  input  logic            clk_pi,
  input  logic            reset_n_pi,
  input  logic            push_pi,
  input  logic [XLEN-1:0] push_pc_pi,
  input  logic [IW-1:0]   idx_pi,
  output logic [XLEN-1:0] pc_po,
  output logic [IW:0]     count_po
);
  localparam logic [IW:0] FULL = (IW+1)'(HIST_DEPTH);
  logic [XLEN-1:0] mem [HIST_DEPTH];
  logic [IW-1:0] wp, ra;
  // power-of-two depth lets the read address wrap naturally
  assign ra = wp - IW'(1) - idx_pi;
  assign pc_po = ({1'b0, idx_pi} < count_po) ? mem[ra] : '0;
  always_ff @(posedge clk_pi)
    if (push_pi) mem[wp] <= push_pc_pi;
  always_ff @(posedge clk_pi or negedge reset_n_pi)
    if (!reset_n_pi) begin
      wp <= '0;
      count_po <= '0;
    end else if (push_pi) begin
      wp <= wp + IW'(1);
      count_po <= (count_po == FULL) ? count_po : count_po + (IW+1)'(1);
    end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: program counter generator with redirects, halt control and issue history
module pc_gen import pc_gen_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEF_TRAP_VECTOR),
  parameter int ILEN_BYTES = DEF_ILEN_BYTES,
  parameter int HIST_DEPTH = DEF_HIST_DEPTH,
  localparam int IW = $clog2(HIST_DEPTH)
) (
  input  logic            clk_pi,
  input  logic            reset_n_pi,
  input  logic            halt_pi,
  input  logic            resume_pi,
  input  logic            branch_taken_pi,
  input  logic [XLEN-1:0] branch_target_pi,
  input  logic            trap_pi,
  input  logic            fetch_ready_pi,
  output logic            fetch_valid_po,
  output logic [XLEN-1:0] pc_po,
  output logic            misalign_po,
  output logic [1:0]      state_po,
  input  logic [IW-1:0]   hist_idx_pi,
  output logic [XLEN-1:0] hist_pc_po,
  output logic [IW:0]     hist_count_po
);
  state_t state_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic live, misal, redirect, fire;
  assign live = state_q != BOOT;
  assign misal = branch_taken_pi & ~trap_pi & |(branch_target_pi & XLEN'(ILEN_BYTES - 1));
  assign redirect = live & (trap_pi | branch_taken_pi);
  assign fetch_valid_po = state_q == RUN;
  // a halting cycle squashes its own request so the PC is reissued on resume
  assign fire = fetch_valid_po & fetch_ready_pi & ~redirect & ~halt_pi;
  assign pc_po = pc_q;
  assign state_po = state_q;
  always_comb
    pc_d = !redirect ? (fire ? pc_q + XLEN'(ILEN_BYTES) : pc_q)
                     : ((trap_pi | misal) ? TRAP_VECTOR : branch_target_pi);
  always_ff @(posedge clk_pi or negedge reset_n_pi)
    if (!reset_n_pi) begin
      state_q <= BOOT;
      pc_q <= RESET_VECTOR;
      misalign_po <= 1'b0;
    end else begin
      pc_q <= pc_d;
      misalign_po <= live & misal;
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: if (halt_pi) state_q <= HALT;
        HALT: if (resume_pi) state_q <= RUN;
        default: state_q <= BOOT;
      endcase
    end
  pc_hist_ring #(.XLEN(XLEN), .HIST_DEPTH(HIST_DEPTH)) u_hist (
    .clk_pi(clk_pi),
    .reset_n_pi(reset_n_pi),
    .push_pi(fire),
    .push_pc_pi(pc_q),
    .idx_pi(hist_idx_pi),
    .pc_po(hist_pc_po),
    .count_po(hist_count_po)
  );
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 0: PC value loaded at reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100: PC value loaded on trap or misaligned redirect.
REQ-004 SHALL have parameter ILEN_BYTES, default 4 (power of two): sequential increment and alignment granule.
REQ-005 SHALL have parameter HIST_DEPTH, default 4 (power of two, >=2): depth of the issued-PC history ring.
REQ-006 SHALL have the following ports (name, direction, width, meaning):
- clk_pi  in  1  clock, rising edge.
- reset_n_pi  in  1  reset, asynchronous, active-low.
- halt_pi  in  1  request to stop issuing fetches.
- resume_pi  in  1  leave HALT.
- branch_taken_pi  in  1  branch redirect request.
- branch_target_pi  in  XLEN  branch target address.
- trap_pi  in  1  trap redirect request.
- fetch_ready_pi  in  1  fetch stage accepts the current PC.
- fetch_valid_po  out  1  current PC is a valid fetch request.
- pc_po  out  XLEN  current PC.
- misalign_po  out  1  one-cycle pulse when a misaligned branch target is converted to a trap.
- state_po  out  2  FSM state: 0 = BOOT, 1 = RUN, 2 = HALT.
- hist_idx_pi  in  log2(HIST_DEPTH)  history read index; 0 = most recent.
- hist_pc_po  out  XLEN  history entry at hist_idx_pi (combinational read).
- hist_count_po  out  log2(HIST_DEPTH)+1  number of valid history entries.

Function
REQ-007 SHALL implement FSM states BOOT, RUN, HALT; BOOT SHALL go to RUN unconditionally after one cycle.
REQ-008 SHALL drive fetch_valid_po = 1 only in RUN.
REQ-009 SHALL, in RUN with fetch_valid_po & fetch_ready_pi and no redirect, load pc <= pc + ILEN_BYTES, with modulo 2^XLEN wrap.
REQ-010 SHALL hold pc when valid is high, ready is low, and there is no redirect.
REQ-011 SHALL apply redirect priority trap_pi > branch_taken_pi > sequential; a redirect SHALL load pc on the next edge regardless of fetch_ready_pi, squashing the current request.
REQ-012 SHALL, when branch_target_pi[log2(ILEN_BYTES)-1:0] != 0 on a taken branch without a trap, load TRAP_VECTOR and pulse misalign_po high for exactly the following cycle.
REQ-013 SHALL accept redirects in every state except BOOT, including HALT, so a branch that coincides with halt is never lost.
REQ-014 SHALL go RUN -> HALT on halt_pi; a same-cycle redirect SHALL still update pc, and the sequential advance SHALL be suppressed.
REQ-015 SHALL go HALT -> RUN on resume_pi, even if halt_pi is also high; resume_pi SHALL be ignored outside HALT.
REQ-016 SHALL, on each accepted fetch (valid & ready), push the pc being issued into the history ring; when full, the oldest entry SHALL be overwritten and hist_count_po SHALL saturate at HIST_DEPTH.
REQ-017 SHALL drive hist_pc_po = 0 when hist_idx_pi >= hist_count_po.
REQ-018 SHALL NOT push redirected or squashed PCs into the history ring.

Reset
REQ-019 SHALL, while reset_n_pi = 0, asynchronously force pc = RESET_VECTOR, state = BOOT, fetch_valid_po = 0, misalign_po = 0, hist_count_po = 0, and ring write pointer = 0.
REQ-020 SHALL, on reset asserted mid-operation (any state, pending redirect), discard all state; the first fetch SHALL issue RESET_VECTOR two edges after deassertion.

Structure
REQ-021 SHALL place the state enum (BOOT/RUN/HALT encodings) and the default parameter constants in shared package pc_gen_pkg.
REQ-022 SHALL implement the history buffer as sub-module pc_hist_ring (parameters XLEN and HIST_DEPTH; push, index read, count).

Verification
REQ-023 SHALL cover reset then ready held at 1 -> BOOT for one cycle, then pc_po = 0, 4, 8 on consecutive cycles, and hist_count_po = 2 after two accepts.
REQ-024 SHALL cover pc = 0x10 with ready = 0 for 3 cycles -> pc_po stays 0x10 and no history push; then ready = 1 -> 0x14.
REQ-025 SHALL cover trap_pi and branch_taken_pi (target 0x40) in the same cycle -> next pc_po = 0x100.
REQ-026 SHALL cover branch target 0x42 -> pc_po = 0x100 and misalign_po = 1 for one cycle.
REQ-027 SHALL cover halt_pi with branch_taken_pi to 0x80 -> state HALT, pc_po = 0x80, fetch_valid_po = 0; then resume_pi -> RUN issuing 0x80.
REQ-028 SHALL cover 6 accepts from 0 with HIST_DEPTH = 4 -> hist_count_po = 4, idx0 = 0x14, idx3 = 0x08; XLEN = 8 with pc = 0xFC -> next pc = 0x00.
